// File: rtl/key_scan_ctrl.sv
// key_scan_ctrl: strobes a 16-key matrix through a 4-to-16 decoder, samples
// the shared return line once per key, debounces over whole scan frames and
// reports one event per debounced key press.
module key_scan_ctrl #(
  parameter int unsigned DWELL    = 4,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_en,
  input  logic       sense,
  output logic [3:0] addr,
  output logic       dec_en,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int unsigned DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DEBOUNCE);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  state_t           r_state;
  logic [DW_W-1:0]  r_dwell;
  logic [3:0]       r_addr;
  logic             r_dec_en;
  logic             r_key_valid;
  logic [3:0]       r_key_code;
  logic             r_key_held;
  logic             r_hit_valid;
  logic [3:0]       r_hit_addr;
  logic             r_cand_valid;
  logic [3:0]       r_cand;
  logic [CNT_W-1:0] r_cnt;

  logic             w_sample;
  logic             w_frame_end;
  logic             w_res_valid;
  logic [3:0]       w_res_addr;
  logic             w_same;
  logic             w_key_lost;
  logic [CNT_W-1:0] w_next_cnt;

  // Sample point is the edge ending the last dwell cycle of an address;
  // the frame closes on the sample point of address 15.
  assign w_sample    = (r_state == S_SCAN) && (r_dwell == DWELL_LAST);
  assign w_frame_end = w_sample && (r_addr == 4'hF);

  // Frame result: earliest latched hit, else the address-15 sample itself.
  assign w_res_valid = r_hit_valid || sense;
  assign w_res_addr  = r_hit_valid ? r_hit_addr : r_addr;
  assign w_same      = r_cand_valid && w_res_valid && (w_res_addr == r_cand);
  assign w_key_lost  = r_key_held && (!w_res_valid || (w_res_addr != r_key_code));

  // Match count after this frame's evaluation (saturates at DEBOUNCE).
  always_comb begin
    w_next_cnt = '0;
    if (w_same) begin
      w_next_cnt = (r_cnt < CNT_MAX) ? r_cnt + 1'b1 : r_cnt;
    end else if (w_res_valid) begin
      w_next_cnt = CNT_W'(1);
    end
  end

  // Scan sequencer, per-frame hit latch and debounce/report state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_dwell      <= '0;
      r_addr       <= 4'd0;
      r_dec_en     <= 1'b0;
      r_key_valid  <= 1'b0;
      r_key_code   <= 4'd0;
      r_key_held   <= 1'b0;
      r_hit_valid  <= 1'b0;
      r_hit_addr   <= 4'd0;
      r_cand_valid <= 1'b0;
      r_cand       <= 4'd0;
      r_cnt        <= '0;
    end else begin
      r_key_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (scan_en) begin
            r_state     <= S_SCAN;
            r_dec_en    <= 1'b1;
            r_addr      <= 4'd0;
            r_dwell     <= '0;
            r_hit_valid <= 1'b0;
          end
        end
        S_SCAN: begin
          if (!scan_en) begin
            // Abort: drop the partial frame and debounce state, keep key_code.
            r_state      <= S_IDLE;
            r_dec_en     <= 1'b0;
            r_addr       <= 4'd0;
            r_dwell      <= '0;
            r_hit_valid  <= 1'b0;
            r_cand_valid <= 1'b0;
            r_cand       <= 4'd0;
            r_cnt        <= '0;
            r_key_held   <= 1'b0;
          end else if (!w_sample) begin
            r_dwell <= r_dwell + 1'b1;
          end else begin
            r_dwell <= '0;
            r_addr  <= r_addr + 4'd1;
            if (w_frame_end) begin
              r_hit_valid  <= 1'b0;
              r_cand_valid <= w_res_valid;
              r_cand       <= w_res_valid ? w_res_addr : 4'd0;
              r_cnt        <= w_next_cnt;
              if ((w_next_cnt == CNT_MAX) && !r_key_held) begin
                r_key_valid <= 1'b1;
                r_key_code  <= w_res_addr;
                r_key_held  <= 1'b1;
              end else if (w_key_lost) begin
                r_key_held <= 1'b0;
              end
            end else if (sense && !r_hit_valid) begin
              r_hit_valid <= 1'b1;
              r_hit_addr  <= r_addr;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign addr      = r_addr;
  assign dec_en    = r_dec_en;
  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;
  assign key_held  = r_key_held;

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Bench for key_scan_ctrl: two instances (DWELL=4/DEBOUNCE=3 and
// DWELL=1/DEBOUNCE=1) compared every cycle against a frame-level model,
// plus directed cycle-exact checks and a randomized phase.
module tb_key_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       scan_en;
  logic       sense0, sense1;
  logic [3:0] addr0, addr1;
  logic       dec0, dec1;
  logic       kv0, kv1;
  logic [3:0] kc0, kc1;
  logic       kh0, kh1;

  key_scan_ctrl #(.DWELL(4), .DEBOUNCE(3)) dut0 (
    .clk(clk), .rst(rst), .scan_en(scan_en), .sense(sense0),
    .addr(addr0), .dec_en(dec0), .key_valid(kv0), .key_code(kc0), .key_held(kh0)
  );

  key_scan_ctrl #(.DWELL(1), .DEBOUNCE(1)) dut1 (
    .clk(clk), .rst(rst), .scan_en(scan_en), .sense(sense1),
    .addr(addr1), .dec_en(dec1), .key_valid(kv1), .key_code(kc1), .key_held(kh1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int t0       = 0;
  int pulses0  = 0;
  int pulses1  = 0;

  // Pressed-key masks presented on each instance's return line.
  bit [15:0] mask [2];

  // Frame-level model state.
  bit        m_scan  [2];
  int        m_tick  [2];
  bit [15:0] m_hits  [2];
  bit        m_cv    [2];
  int        m_cand  [2];
  int        m_cnt   [2];
  bit        m_held  [2];
  int        m_code  [2];
  bit        m_valid [2];

  function automatic int dw_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int db_of(input int i);
    return (i == 0) ? 3 : 1;
  endfunction

  function automatic int m_addr(input int i);
    return m_scan[i] ? (m_tick[i] / dw_of(i)) : 0;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc - t0);
    end
  endtask

  // Advance the model by one clock edge using the inputs sampled at it.
  task automatic m_update(input int i, input bit r, input bit en, input bit s);
    int d;
    int a;
    int lo;
    d = dw_of(i);
    if (r) begin
      m_scan[i] = 0; m_tick[i] = 0; m_hits[i] = '0; m_cv[i] = 0; m_cand[i] = 0;
      m_cnt[i] = 0; m_held[i] = 0; m_code[i] = 0; m_valid[i] = 0;
      return;
    end
    m_valid[i] = 0;
    if (!m_scan[i]) begin
      if (en) begin
        m_scan[i] = 1; m_tick[i] = 0; m_hits[i] = '0;
      end
      return;
    end
    if (!en) begin
      m_scan[i] = 0; m_tick[i] = 0; m_hits[i] = '0; m_cv[i] = 0; m_cand[i] = 0;
      m_cnt[i] = 0; m_held[i] = 0;
      return;
    end
    a = m_tick[i] / d;
    if (((m_tick[i] % d) == d - 1) && s) m_hits[i][a] = 1'b1;
    if (m_tick[i] == 16 * d - 1) begin
      lo = -1;
      for (int k = 15; k >= 0; k--) if (m_hits[i][k]) lo = k;
      if (lo >= 0) begin
        if (m_cv[i] && m_cand[i] == lo) begin
          if (m_cnt[i] < db_of(i)) m_cnt[i]++;
        end else begin
          m_cv[i] = 1; m_cand[i] = lo; m_cnt[i] = 1;
        end
      end else begin
        m_cv[i] = 0; m_cand[i] = 0; m_cnt[i] = 0;
      end
      if (m_cnt[i] == db_of(i) && !m_held[i]) begin
        m_valid[i] = 1; m_code[i] = m_cand[i]; m_held[i] = 1;
      end else if (m_held[i] && (lo < 0 || lo != m_code[i])) begin
        m_held[i] = 0;
      end
      m_hits[i] = '0;
      m_tick[i] = 0;
    end else begin
      m_tick[i]++;
    end
  endtask

  task automatic cmp_inst(input int i, input logic [3:0] a, input logic de,
                          input logic kv, input logic [3:0] kc, input logic kh);
    check($sformatf("u%0d_addr", i),      int'(a),  m_addr(i));
    check($sformatf("u%0d_dec_en", i),    int'(de), int'(m_scan[i]));
    check($sformatf("u%0d_key_valid", i), int'(kv), int'(m_valid[i]));
    check($sformatf("u%0d_key_code", i),  int'(kc), m_code[i]);
    check($sformatf("u%0d_key_held", i),  int'(kh), int'(m_held[i]));
  endtask

  // One clock: present sense, update the model at the edge, compare after it.
  task automatic step();
    sense0 = mask[0][m_addr(0)];
    sense1 = mask[1][m_addr(1)];
    @(posedge clk);
    m_update(0, rst, scan_en, sense0);
    m_update(1, rst, scan_en, sense1);
    #1;
    cyc++;
    if (kv0) pulses0++;
    if (kv1) pulses1++;
    cmp_inst(0, addr0, dec0, kv0, kc0, kh0);
    cmp_inst(1, addr1, dec1, kv1, kc1, kh1);
  endtask

  task automatic run_to(input int k);
    while ((cyc - t0) < k) step();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    rst = 1'b1; scan_en = 1'b0; sense0 = 1'b0; sense1 = 1'b0;
    mask[0] = '0; mask[1] = '0;
    run(2);
    check("rst_addr", int'(addr0), 0);
    check("rst_dec_en", int'(dec0), 0);
    check("rst_key_valid", int'(kv0), 0);
    check("rst_key_code", int'(kc0), 0);
    check("rst_key_held", int'(kh0), 0);
    rst = 1'b0;
    run(3);

    // Key 5 on the slow instance, key 15 on the fast one.
    mask[0] = 16'h0020; mask[1] = 16'h8000;
    scan_en = 1'b1; t0 = cyc;
    pulses0 = 0; pulses1 = 0;
    run_to(1);
    check("c1_dec_en", int'(dec0), 1);
    check("c1_addr", int'(addr0), 0);
    check("fast_c1_addr", int'(addr1), 0);
    run_to(2);
    check("fast_c2_addr", int'(addr1), 1);
    run_to(5);
    check("c5_addr", int'(addr0), 1);
    run_to(16);
    check("fast_c16_valid", int'(kv1), 0);
    run_to(17);
    check("fast_c17_valid", int'(kv1), 1);
    check("fast_c17_code", int'(kc1), 15);
    check("fast_c17_addr", int'(addr1), 0);
    run_to(64);
    check("c64_addr", int'(addr0), 15);
    run_to(65);
    check("c65_addr_wrap", int'(addr0), 0);
    run_to(192);
    check("c192_valid", int'(kv0), 0);
    check("c192_pulses", pulses0, 0);
    run_to(193);
    check("c193_valid", int'(kv0), 1);
    check("c193_code", int'(kc0), 5);
    check("c193_held", int'(kh0), 1);
    run_to(194);
    check("c194_valid", int'(kv0), 0);
    // Held for ten more frames: no repeat, then release.
    run_to(832);
    check("hold_pulses", pulses0, 1);
    check("fast_hold_pulses", pulses1, 1);
    mask[0] = '0;
    run_to(896);
    check("c896_held", int'(kh0), 1);
    run_to(897);
    check("c897_held", int'(kh0), 0);
    check("c897_code", int'(kc0), 5);

    // Keys 3 and 9 together: lowest address wins.
    mask[0] = 16'h0208;
    run_to(1089);
    check("multi_valid", int'(kv0), 1);
    check("multi_code", int'(kc0), 3);
    run_to(1152);
    check("multi_pulses", pulses0, 2);
    mask[0] = '0;

    // Key 12: frames 20-21 present, 22 absent, 23-25 present.
    run_to(1216);
    mask[0] = 16'h1000;
    run_to(1344);
    mask[0] = '0;
    run_to(1408);
    mask[0] = 16'h1000;
    run_to(1600);
    check("gap_no_early_pulse", pulses0, 2);
    run_to(1601);
    check("gap_valid", int'(kv0), 1);
    check("gap_code", int'(kc0), 12);
    run_to(1664);
    mask[0] = '0;

    // Key 7 reported, then scan aborted mid-frame.
    run_to(1728);
    mask[0] = 16'h0080;
    run_to(1921);
    check("k7_valid", int'(kv0), 1);
    check("k7_code", int'(kc0), 7);
    run_to(1941);
    scan_en = 1'b0;
    step();
    check("abort_dec_en", int'(dec0), 0);
    check("abort_addr", int'(addr0), 0);
    check("abort_held", int'(kh0), 0);
    check("abort_code", int'(kc0), 7);
    check("abort_valid", int'(kv0), 0);
    run(5);
    check("abort_pulses", pulses0, 4);
    scan_en = 1'b1; t0 = cyc;
    run_to(192);
    check("reen_c192_valid", int'(kv0), 0);
    run_to(193);
    check("reen_c193_valid", int'(kv0), 1);
    check("reen_c193_code", int'(kc0), 7);

    // Reset mid-frame.
    run(30);
    rst = 1'b1;
    step();
    check("midrst_addr", int'(addr0), 0);
    check("midrst_dec_en", int'(dec0), 0);
    check("midrst_code", int'(kc0), 0);
    check("midrst_held", int'(kh0), 0);
    check("midrst_fast_code", int'(kc1), 0);
    check("midrst_fast_held", int'(kh1), 0);
    rst = 1'b0;

    // Randomized phase: key masks, scan enable and reset toggled at random.
    for (int k = 0; k < 6000; k++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 149) == 0) begin
          case ($urandom_range(0, 3))
            0:       mask[i] = '0;
            1:       mask[i] = 16'h0001 << $urandom_range(0, 15);
            2:       mask[i] = (16'h0001 << $urandom_range(0, 15)) |
                               (16'h0001 << $urandom_range(0, 15));
            default: mask[i] = 16'($urandom);
          endcase
        end
      end
      if ($urandom_range(0, 399) == 0) scan_en = ~scan_en;
      if (!scan_en && $urandom_range(0, 19) == 0) scan_en = 1'b1;
      rst = ($urandom_range(0, 1499) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
